// File: rtl/led_peripheral_if.sv
// Interconnect-side register access bus for the LED peripheral.
// The interconnect is the master; the peripheral answers reads combinationally.
interface led_peripheral_if;
    logic        rd_en_i;
    logic        wr_en_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (
        output rd_en_i,
        output wr_en_i,
        output addr_i,
        output data_i,
        input  data_o
    );

    modport slave (
        input  rd_en_i,
        input  wr_en_i,
        input  addr_i,
        input  data_i,
        output data_o
    );
endinterface

// File: rtl/led_peripheral.sv
// Memory-mapped LED controller: static, blink and PWM-dimmed LED drive
// with a small register file decoded on addr_i[4:2].
module led_peripheral #(
    parameter int          NUM_LEDS     = 8,
    parameter logic [31:0] RESET_PERIOD = 32'd25000000
) (
    input  logic                clk,
    input  logic                rst_n,
    led_peripheral_if.slave     bus,
    output logic [NUM_LEDS-1:0] led_o
);
    localparam logic [2:0] OFS_LED_DATA = 3'd0;
    localparam logic [2:0] OFS_CTRL     = 3'd1;
    localparam logic [2:0] OFS_PERIOD   = 3'd2;
    localparam logic [2:0] OFS_DUTY     = 3'd3;
    localparam logic [2:0] OFS_TOGGLE   = 3'd4;
    localparam logic [2:0] OFS_STATUS   = 3'd5;

    logic [NUM_LEDS-1:0] led_data_reg;
    logic                blink_en_reg;
    logic                pwm_en_reg;
    logic [31:0]         blink_period_reg;
    logic [7:0]          pwm_duty_reg;
    logic [15:0]         toggle_cnt_reg;
    logic [31:0]         blink_cnt_reg;
    logic                phase_reg;
    logic [7:0]          pwm_cnt_reg;
    logic [NUM_LEDS-1:0] led_reg;

    logic [31:0]         blink_cnt_next;
    logic                phase_next;
    logic [15:0]         toggle_cnt_next;
    logic [7:0]          pwm_cnt_next;
    logic [NUM_LEDS-1:0] led_next;
    logic                toggle_evt;
    logic                pwm_on;
    logic                led_gate;
    logic [31:0]         rdata;

    logic [2:0] sel;
    logic       wr_led, wr_ctrl, wr_period, wr_duty, wr_toggle;
    logic       unused_addr_bits;

    assign sel              = bus.addr_i[4:2];
    assign unused_addr_bits = ^{bus.addr_i[31:5], bus.addr_i[1:0]};

    assign wr_led    = bus.wr_en_i && (sel == OFS_LED_DATA);
    assign wr_ctrl   = bus.wr_en_i && (sel == OFS_CTRL);
    assign wr_period = bus.wr_en_i && (sel == OFS_PERIOD);
    assign wr_duty   = bus.wr_en_i && (sel == OFS_DUTY);
    assign wr_toggle = bus.wr_en_i && (sel == OFS_TOGGLE);

    // Restart writes take priority over the engines, so no toggle is counted then.
    always_comb begin
        blink_cnt_next = blink_cnt_reg;
        phase_next     = phase_reg;
        toggle_evt     = 1'b0;
        if (blink_en_reg) begin
            if (blink_period_reg == 32'd0) begin
                blink_cnt_next = 32'd0;
            end else if (blink_cnt_reg == blink_period_reg - 32'd1) begin
                blink_cnt_next = 32'd0;
                phase_next     = ~phase_reg;
                toggle_evt     = 1'b1;
            end else begin
                blink_cnt_next = blink_cnt_reg + 32'd1;
            end
        end
        if (wr_ctrl) begin
            blink_cnt_next = 32'd0;
            phase_next     = 1'b1;
            toggle_evt     = 1'b0;
        end else if (wr_period) begin
            blink_cnt_next = 32'd0;
            phase_next     = phase_reg;
            toggle_evt     = 1'b0;
        end
    end

    always_comb begin
        toggle_cnt_next = toggle_cnt_reg + {15'd0, toggle_evt};
        if (wr_toggle) begin
            toggle_cnt_next = 16'd0;
        end
        pwm_cnt_next = pwm_cnt_reg;
        if (wr_ctrl) begin
            pwm_cnt_next = 8'd0;
        end else if (pwm_en_reg) begin
            pwm_cnt_next = pwm_cnt_reg + 8'd1;
        end
    end

    assign pwm_on   = ~pwm_en_reg | (pwm_duty_reg == 8'hFF) | (pwm_cnt_reg < pwm_duty_reg);
    assign led_gate = (~blink_en_reg | phase_reg) & pwm_on;

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            assign led_next[gi] = led_data_reg[gi] & led_gate;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_data_reg     <= '0;
            blink_en_reg     <= 1'b0;
            pwm_en_reg       <= 1'b0;
            blink_period_reg <= RESET_PERIOD;
            pwm_duty_reg     <= 8'd0;
            toggle_cnt_reg   <= 16'd0;
            blink_cnt_reg    <= 32'd0;
            phase_reg        <= 1'b1;
            pwm_cnt_reg      <= 8'd0;
            led_reg          <= '0;
        end else begin
            if (wr_led)    led_data_reg     <= bus.data_i[NUM_LEDS-1:0];
            if (wr_ctrl) begin
                blink_en_reg <= bus.data_i[0];
                pwm_en_reg   <= bus.data_i[1];
            end
            if (wr_period) blink_period_reg <= bus.data_i;
            if (wr_duty)   pwm_duty_reg     <= bus.data_i[7:0];
            toggle_cnt_reg <= toggle_cnt_next;
            blink_cnt_reg  <= blink_cnt_next;
            phase_reg      <= phase_next;
            pwm_cnt_reg    <= pwm_cnt_next;
            led_reg        <= led_next;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (sel)
            OFS_LED_DATA: rdata[NUM_LEDS-1:0] = led_data_reg;
            OFS_CTRL:     rdata[1:0]          = {pwm_en_reg, blink_en_reg};
            OFS_PERIOD:   rdata               = blink_period_reg;
            OFS_DUTY:     rdata[7:0]          = pwm_duty_reg;
            OFS_TOGGLE:   rdata[15:0]         = toggle_cnt_reg;
            OFS_STATUS:   rdata[1:0]          = {pwm_on, phase_reg};
            default:      rdata               = 32'd0;
        endcase
    end

    assign bus.data_o = bus.rd_en_i ? rdata : 32'd0;
    assign led_o      = led_reg;
endmodule

// File: tb/tb_led_peripheral.sv
// Directed self-checking bench for led_peripheral: register map, blink,
// PWM, read/write collision and reset behaviour.
module tb_led_peripheral;
    localparam logic [31:0] RST_PER = 32'd25000000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] led_o;
    int         errors = 0;
    int         checks = 0;

    led_peripheral_if bus ();

    led_peripheral #(.NUM_LEDS(8), .RESET_PERIOD(RST_PER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master),
        .led_o (led_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.wr_en_i = 1'b1;
        bus.addr_i  = a;
        bus.data_i  = d;
        @(posedge clk);
        #1;
        bus.wr_en_i = 1'b0;
        $display("wr addr=%h data=%h", a, d);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.rd_en_i = 1'b1;
        bus.addr_i  = a;
        #1;
        d = bus.data_o;
        bus.rd_en_i = 1'b0;
        $display("rd addr=%h data=%h", a, d);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        bus.rd_en_i = 1'b0; bus.wr_en_i = 1'b0;
        bus.addr_i = 32'h8000_0008; bus.data_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (led_o !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led_o); end
        checks++;
        if (bus.data_o !== 32'd0) begin errors++; $display("FAIL reset_rd_idle: got %h expected 0", bus.data_o); end
        rst_n = 1'b1;
        rd(32'h8000_0008, d);
        checks++;
        if (d !== RST_PER) begin errors++; $display("FAIL reset_period: got %h expected %h", d, RST_PER); end
        rd(32'h8000_0004, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", d); end
        rd(32'h8000_0014, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL reset_status: got %h expected 3", d); end
    endtask

    task automatic test_led_data();
        logic [31:0] d;
        wr(32'h8000_0000, 32'h0000_00A5);
        checks++;
        if (led_o !== 8'h00) begin errors++; $display("FAIL led_latency: got %h expected 00", led_o); end
        @(posedge clk); #1;
        checks++;
        if (led_o !== 8'hA5) begin errors++; $display("FAIL led_static: got %h expected a5", led_o); end
        rd(32'h8000_0000, d);
        checks++;
        if (d !== 32'h0000_00A5) begin errors++; $display("FAIL led_read: got %h expected 000000a5", d); end
        wr(32'h8000_0000, 32'hFFFF_FF00);
        rd(32'h8000_0000, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL led_upper: got %h expected 0", d); end
    endtask

    task automatic test_blink();
        logic [31:0] d;
        logic [7:0]  exp;
        wr(32'h8000_0008, 32'd4);
        wr(32'h8000_0000, 32'hFF);
        wr(32'h8000_0004, 32'd1);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            exp = (((n - 1) / 4) % 2 == 0) ? 8'hFF : 8'h00;
            checks++;
            if (led_o !== exp) begin errors++; $display("FAIL blink_led[%0d]: got %h expected %h", n, led_o, exp); end
        end
        rd(32'h8000_0010, d);
        checks++;
        if (d !== 32'd5) begin errors++; $display("FAIL blink_toggles: got %h expected 5", d); end
        rd(32'h8000_0014, d);
        checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL blink_status: got %h expected 2", d); end
        wr(32'h8000_0010, 32'h1234);
        rd(32'h8000_0010, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL toggle_clear: got %h expected 0", d); end
        wr(32'h8000_0008, 32'd0);
        @(posedge clk); #1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            checks++;
            if (led_o !== 8'h00) begin errors++; $display("FAIL blink_frozen[%0d]: got %h expected 00", n, led_o); end
        end
        rd(32'h8000_0010, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL frozen_toggles: got %h expected 0", d); end
    endtask

    task automatic pwm_window(input logic [7:0] duty, input int exp_hi);
        logic [31:0] d;
        int led_hi;
        int st_hi;
        led_hi = 0;
        st_hi  = 0;
        for (int i = 0; i < 256; i++) begin
            rd(32'h8000_0014, d);
            st_hi += int'(d[1]);
            @(posedge clk); #1;
            led_hi += int'(led_o[0]);
        end
        checks++;
        if (led_hi !== exp_hi) begin errors++; $display("FAIL pwm_led duty=%h: got %0d expected %0d", duty, led_hi, exp_hi); end
        checks++;
        if (st_hi !== exp_hi) begin errors++; $display("FAIL pwm_status duty=%h: got %0d expected %0d", duty, st_hi, exp_hi); end
    endtask

    task automatic test_pwm();
        wr(32'h8000_0000, 32'h01);
        wr(32'h8000_000C, 32'd64);
        wr(32'h8000_0004, 32'd2);
        pwm_window(8'd64, 64);
        wr(32'h8000_000C, 32'd0);
        pwm_window(8'd0, 0);
        wr(32'h8000_000C, 32'hFF);
        pwm_window(8'hFF, 256);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        wr(32'h8000_000C, 32'h10);
        bus.rd_en_i = 1'b1; bus.wr_en_i = 1'b1;
        bus.addr_i  = 32'h8000_000C; bus.data_i = 32'h20;
        #1;
        checks++;
        if (bus.data_o !== 32'h10) begin errors++; $display("FAIL rdwr_old: got %h expected 10", bus.data_o); end
        @(posedge clk); #1;
        bus.wr_en_i = 1'b0;
        checks++;
        if (bus.data_o !== 32'h20) begin errors++; $display("FAIL rdwr_new: got %h expected 20", bus.data_o); end
        bus.rd_en_i = 1'b0;
        wr(32'h8000_0014, 32'hFFFF_FFFF);
        wr(32'h8000_0018, 32'hFFFF_FFFF);
        wr(32'h8000_001C, 32'hFFFF_FFFF);
        rd(32'h8000_0000, d);
        checks++;
        if (d !== 32'h01) begin errors++; $display("FAIL ro_led: got %h expected 1", d); end
        rd(32'h8000_0004, d);
        checks++;
        if (d !== 32'h02) begin errors++; $display("FAIL ro_ctrl: got %h expected 2", d); end
        rd(32'h8000_0008, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL ro_period: got %h expected 0", d); end
        rd(32'h8000_000C, d);
        checks++;
        if (d !== 32'h20) begin errors++; $display("FAIL ro_duty: got %h expected 20", d); end
        rd(32'h8000_0018, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL rsv_18: got %h expected 0", d); end
        rd(32'h8000_001C, d);
        checks++;
        if (d !== 32'h00) begin errors++; $display("FAIL rsv_1c: got %h expected 0", d); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        wr(32'h8000_0008, 32'd3);
        wr(32'h8000_0000, 32'hFF);
        wr(32'h8000_0004, 32'd3);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.wr_en_i = 1'b1; bus.addr_i = 32'h8000_0000; bus.data_i = 32'hAA;
        @(posedge clk); #1;
        bus.wr_en_i = 1'b0;
        checks++;
        if (led_o !== 8'h00) begin errors++; $display("FAIL mrst_led: got %h expected 00", led_o); end
        rd(32'h8000_0000, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mrst_data: got %h expected 0", d); end
        rd(32'h8000_0004, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mrst_ctrl: got %h expected 0", d); end
        rd(32'h8000_0008, d);
        checks++;
        if (d !== RST_PER) begin errors++; $display("FAIL mrst_period: got %h expected %h", d, RST_PER); end
        rd(32'h8000_000C, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mrst_duty: got %h expected 0", d); end
        rd(32'h8000_0010, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL mrst_toggle: got %h expected 0", d); end
        rd(32'h8000_0014, d);
        checks++;
        if (d !== 32'd3) begin errors++; $display("FAIL mrst_status: got %h expected 3", d); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_led_data();
        test_blink();
        test_pwm();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
